daten_bus_verteiler: RTL and testbench
======================================

DATEN_BUS_VERTEILER -- requirements
Module: daten_bus_verteiler

Interface
REQ-001 SHALL have parameter DATENBREITE, default 32, CPU/RAM data width (>=8).
REQ-002 SHALL have parameter RAM_ADRESSBREITE, default 8, data-RAM word address width.
REQ-003 SHALL have parameter LED_BREITE, default 8, LED register width (<=DATENBREITE).
REQ-004 SHALL have parameter TASTER_BREITE, default 4, button input width (<=DATENBREITE).
REQ-005 SHALL have parameter TIMEOUT_ZYKLEN, default 16, RAM wait limit in cycles (>=1).
REQ-006 SHALL have ports: Clock  in  1  single clock, all logic on rising edge.
REQ-007 Reset  in  1  synchronous, active-low reset.
REQ-008 DatenAdresse  in  32  CPU data address; bit 31 = 1 selects IO, 0 selects RAM.
REQ-009 DatenVonCPU  in  DATENBREITE  CPU write data.
REQ-010 LeseDaten / SchreibeDaten  in  1 each  CPU read/write request, held high until acknowledged.
REQ-011 DatenZuCPU  out  DATENBREITE  read data, valid during DatenGeladen.
REQ-012 DatenGeladen / DatenGespeichert  out  1 each  single-cycle read/write acknowledge.
REQ-013 RAMAdresse  out  RAM_ADRESSBREITE; RAMDatenRein  out  DATENBREITE; RAMLesenAn / RAMSchreibenAn  out  1 each.
REQ-014 RAMDatenRaus  in  DATENBREITE; RAMDatenBereit / RAMDatenGeschrieben  in  1 each  RAM completion.
REQ-015 Taster  in  TASTER_BREITE  asynchronous buttons; Led  out  LED_BREITE; BusFehler  out  1  sticky error flag.

Function
REQ-016 SHALL implement FSM states LEERLAUF, RAM_WARTEN, QUITTUNG; requests accepted only in LEERLAUF.
REQ-017 Both LeseDaten and SchreibeDaten high in LEERLAUF: write SHALL win, read ignored.
REQ-018 On acceptance SHALL latch address (RAMAdresse = DatenAdresse[RAM_ADRESSBREITE-1:0]), write data and direction.
REQ-019 RAM request: LEERLAUF->RAM_WARTEN; matching RAM strobe held high from next cycle until RAMDatenBereit/RAMDatenGeschrieben sampled high.
REQ-020 On RAM completion: strobe low, read data latched, ->QUITTUNG; ack asserted in QUITTUNG; latency = RAM latency + 2 cycles.
REQ-021 IO request: LEERLAUF->QUITTUNG directly; ack one cycle after request sampled; no RAM strobe asserted.
REQ-022 QUITTUNG lasts exactly one cycle, then LEERLAUF; a request held through QUITTUNG is re-accepted as a new access.
REQ-023 IO map, index DatenAdresse[3:2]: 0 Led RW (low LED_BREITE bits), 1 Taster RO, 2 Zykluszaehler RO, 3 status RO (bit0 = BusFehler).
REQ-024 Taster SHALL pass a 2-flop synchroniser; reads zero-extended; unused read bits 0.
REQ-025 Zykluszaehler SHALL be DATENBREITE wide, +1 every cycle, wrap to 0 from all-ones.
REQ-026 Writes to indices 1-3 SHALL be ignored but still acknowledged; Led updates in the QUITTUNG cycle.
REQ-027 DatenZuCPU SHALL hold the last read value outside DatenGeladen.

Reset
REQ-028 Reset low in any state SHALL force LEERLAUF next edge: acks, RAM strobes, Led, DatenZuCPU, Zykluszaehler, synchroniser, BusFehler all 0.
REQ-029 Reset mid-access SHALL abort it without acknowledge; RAM completion arriving during Reset ignored.

Configuration
REQ-030 Macro DATEN_BUS_TIMEOUT_EN defined: wait counter runs in RAM_WARTEN; at TIMEOUT_ZYKLEN cycles without completion -> strobe low, BusFehler set, read data 0xDEADBEEF truncated to DATENBREITE, ->QUITTUNG with normal ack.
REQ-031 With macro: BusFehler clears only on Reset or IO write index 3 with DatenVonCPU[0]=1.
REQ-032 Macro undefined: no counter, RAM_WARTEN waits indefinitely, BusFehler tied 0.

Verification
REQ-033 RAM write 0x12345678 at 0x05, RAM acks after 2 cycles -> RAMSchreibenAn high 2 cycles, DatenGespeichert one pulse, total 4 cycles.
REQ-034 IO write 0x000000A5 to 0x80000000 then read -> Led=0xA5 after ack; read returns 0x000000A5, DatenGeladen 1 cycle after request.
REQ-035 Taster=4'b1010 stable, read 0x80000004 -> 0x0000000A; read 0x80000008 twice 10 cycles apart -> difference 10+access offset, wrap from 0xFFFFFFFF to 0.
REQ-036 LeseDaten and SchreibeDaten both high to IO index 0 -> only DatenGespeichert pulses, Led written.
REQ-037 With DATEN_BUS_TIMEOUT_EN, RAM never answers -> after 16 wait cycles DatenZuCPU=0xDEADBEEF, BusFehler=1; write 1 to 0x8000000C clears it.
REQ-038 Reset low during RAM_WARTEN -> next cycle RAM strobes 0, no ack, Led 0, FSM in LEERLAUF.

Source files
------------

// File: rtl/daten_bus_verteiler.sv
// Data bus splitter: routes CPU data accesses to the data RAM or to a small IO block (LEDs, buttons, cycle counter, status).
// Optional RAM wait timeout with sticky bus error is enabled by defining DATEN_BUS_TIMEOUT_EN.
module daten_bus_verteiler #(
   parameter int unsigned DATENBREITE      = 32,
   parameter int unsigned RAM_ADRESSBREITE = 8,
   parameter int unsigned LED_BREITE       = 8,
   parameter int unsigned TASTER_BREITE    = 4,
   parameter int unsigned TIMEOUT_ZYKLEN   = 16
) (
   input  logic                        Clock,
   input  logic                        Reset,
   input  logic [31:0]                 DatenAdresse,
   input  logic [DATENBREITE-1:0]      DatenVonCPU,
   input  logic                        LeseDaten,
   input  logic                        SchreibeDaten,
   output logic [DATENBREITE-1:0]      DatenZuCPU,
   output logic                        DatenGeladen,
   output logic                        DatenGespeichert,
   output logic [RAM_ADRESSBREITE-1:0] RAMAdresse,
   output logic [DATENBREITE-1:0]      RAMDatenRein,
   output logic                        RAMLesenAn,
   output logic                        RAMSchreibenAn,
   input  logic [DATENBREITE-1:0]      RAMDatenRaus,
   input  logic                        RAMDatenBereit,
   input  logic                        RAMDatenGeschrieben,
   input  logic [TASTER_BREITE-1:0]    Taster,
   output logic [LED_BREITE-1:0]       Led,
   output logic                        BusFehler
);

   typedef enum logic [1:0] {LEERLAUF, RAM_WARTEN, QUITTUNG} zustand_t;

   zustand_t                 zustand;
   logic                     istSchreiben;
   logic [DATENBREITE-1:0]   zyklusZaehler;
   logic [TASTER_BREITE-1:0] tasterSync1;
   logic [TASTER_BREITE-1:0] tasterSync2;
   logic [DATENBREITE-1:0]   ioLeseWert;
   logic                     ramFertig;
   logic                     unusedBits;

`ifdef DATEN_BUS_TIMEOUT_EN
   localparam int unsigned WARTE_BREITE = $clog2(TIMEOUT_ZYKLEN + 1);
   localparam logic [31:0] FEHLER_WERT  = 32'hDEADBEEF;
   logic [WARTE_BREITE-1:0] warteZaehler;
   logic                    busFehlerReg;
   assign BusFehler  = busFehlerReg;
   assign unusedBits = ^{DatenAdresse[30:4]};
`else
   assign BusFehler  = 1'b0;
   assign unusedBits = ^{DatenAdresse[30:4], 32'(TIMEOUT_ZYKLEN)};
`endif

   // IO read mux, selected by the live address while the request is accepted
   always_comb begin
      ioLeseWert = '0;
      case (DatenAdresse[3:2])
         2'd0:    ioLeseWert = DATENBREITE'(Led);
         2'd1:    ioLeseWert = DATENBREITE'(tasterSync2);
         2'd2:    ioLeseWert = zyklusZaehler;
         default: ioLeseWert = DATENBREITE'(BusFehler);
      endcase
   end

   assign ramFertig = istSchreiben ? RAMDatenGeschrieben : RAMDatenBereit;

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         zustand          <= LEERLAUF;
         istSchreiben     <= 1'b0;
         zyklusZaehler    <= '0;
         tasterSync1      <= '0;
         tasterSync2      <= '0;
         DatenZuCPU       <= '0;
         DatenGeladen     <= 1'b0;
         DatenGespeichert <= 1'b0;
         RAMAdresse       <= '0;
         RAMDatenRein     <= '0;
         RAMLesenAn       <= 1'b0;
         RAMSchreibenAn   <= 1'b0;
         Led              <= '0;
`ifdef DATEN_BUS_TIMEOUT_EN
         warteZaehler     <= '0;
         busFehlerReg     <= 1'b0;
`endif
      end else begin
         zyklusZaehler    <= zyklusZaehler + DATENBREITE'(1);
         tasterSync1      <= Taster;
         tasterSync2      <= tasterSync1;
         DatenGeladen     <= 1'b0;
         DatenGespeichert <= 1'b0;
         case (zustand)
            LEERLAUF: begin
               // write wins when both requests are raised together
               if (SchreibeDaten || LeseDaten) begin
                  istSchreiben <= SchreibeDaten;
                  RAMAdresse   <= DatenAdresse[RAM_ADRESSBREITE-1:0];
                  RAMDatenRein <= DatenVonCPU;
                  if (DatenAdresse[31]) begin
                     zustand <= QUITTUNG;
                     if (SchreibeDaten) begin
                        DatenGespeichert <= 1'b1;
                        if (DatenAdresse[3:2] == 2'd0)
                           Led <= DatenVonCPU[LED_BREITE-1:0];
`ifdef DATEN_BUS_TIMEOUT_EN
                        if (DatenAdresse[3:2] == 2'd3 && DatenVonCPU[0])
                           busFehlerReg <= 1'b0;
`endif
                     end else begin
                        DatenGeladen <= 1'b1;
                        DatenZuCPU   <= ioLeseWert;
                     end
                  end else begin
                     zustand        <= RAM_WARTEN;
                     RAMSchreibenAn <= SchreibeDaten;
                     RAMLesenAn     <= !SchreibeDaten;
`ifdef DATEN_BUS_TIMEOUT_EN
                     warteZaehler   <= '0;
`endif
                  end
               end
            end
            RAM_WARTEN: begin
               if (ramFertig) begin
                  zustand        <= QUITTUNG;
                  RAMLesenAn     <= 1'b0;
                  RAMSchreibenAn <= 1'b0;
                  if (istSchreiben) begin
                     DatenGespeichert <= 1'b1;
                  end else begin
                     DatenGeladen <= 1'b1;
                     DatenZuCPU   <= RAMDatenRaus;
                  end
               end
`ifdef DATEN_BUS_TIMEOUT_EN
               // RAM silent too long: abort with error value and a normal acknowledge
               else if (warteZaehler == WARTE_BREITE'(TIMEOUT_ZYKLEN - 1)) begin
                  zustand        <= QUITTUNG;
                  RAMLesenAn     <= 1'b0;
                  RAMSchreibenAn <= 1'b0;
                  busFehlerReg   <= 1'b1;
                  if (istSchreiben) begin
                     DatenGespeichert <= 1'b1;
                  end else begin
                     DatenGeladen <= 1'b1;
                     DatenZuCPU   <= DATENBREITE'(FEHLER_WERT);
                  end
               end else begin
                  warteZaehler <= warteZaehler + WARTE_BREITE'(1);
               end
`endif
            end
            QUITTUNG: zustand <= LEERLAUF;
            default:  zustand <= LEERLAUF;
         endcase
      end
   end

endmodule

// File: tb/tb_daten_bus_verteiler.sv
// Directed bench for daten_bus_verteiler: vector table plus hand sequences for reset, counter, re-accept and timeout.
// The timeout sequence is built only when DATEN_BUS_TIMEOUT_EN is defined.
module tb_daten_bus_verteiler;
   logic        Clock = 1'b0;
   logic        Reset;
   logic [31:0] DatenAdresse;
   logic [31:0] DatenVonCPU;
   logic        LeseDaten;
   logic        SchreibeDaten;
   logic [31:0] DatenZuCPU;
   logic        DatenGeladen;
   logic        DatenGespeichert;
   logic [7:0]  RAMAdresse;
   logic [31:0] RAMDatenRein;
   logic        RAMLesenAn;
   logic        RAMSchreibenAn;
   logic [31:0] RAMDatenRaus = '0;
   logic        RAMDatenBereit = 1'b0;
   logic        RAMDatenGeschrieben = 1'b0;
   logic [3:0]  Taster;
   logic [7:0]  Led;
   logic        BusFehler;

   int total = 0;
   int bad = 0;
   int ramLatenz = 0;
   int strobeZaehler = 0;
   int tbZyklen = 0;
   logic [31:0] ramSpeicher [256];

   daten_bus_verteiler dut (
      .Clock(Clock), .Reset(Reset), .DatenAdresse(DatenAdresse), .DatenVonCPU(DatenVonCPU),
      .LeseDaten(LeseDaten), .SchreibeDaten(SchreibeDaten), .DatenZuCPU(DatenZuCPU),
      .DatenGeladen(DatenGeladen), .DatenGespeichert(DatenGespeichert), .RAMAdresse(RAMAdresse),
      .RAMDatenRein(RAMDatenRein), .RAMLesenAn(RAMLesenAn), .RAMSchreibenAn(RAMSchreibenAn),
      .RAMDatenRaus(RAMDatenRaus), .RAMDatenBereit(RAMDatenBereit),
      .RAMDatenGeschrieben(RAMDatenGeschrieben), .Taster(Taster), .Led(Led), .BusFehler(BusFehler)
   );

   always #5 Clock = ~Clock;

   // independent count of clock edges seen with reset released
   always @(posedge Clock) begin
      if (!Reset) tbZyklen <= 0;
      else        tbZyklen <= tbZyklen + 1;
   end

   // RAM model: answers after ramLatenz strobe cycles; ramLatenz 0 never answers
   always @(negedge Clock) begin
      if (RAMLesenAn || RAMSchreibenAn) begin
         strobeZaehler = strobeZaehler + 1;
         if (ramLatenz != 0 && strobeZaehler == ramLatenz) begin
            if (RAMSchreibenAn) begin
               ramSpeicher[RAMAdresse] = RAMDatenRein;
               RAMDatenGeschrieben = 1'b1;
            end else begin
               RAMDatenRaus = ramSpeicher[RAMAdresse];
               RAMDatenBereit = 1'b1;
            end
         end
      end else begin
         strobeZaehler = 0;
         RAMDatenBereit = 1'b0;
         RAMDatenGeschrieben = 1'b0;
      end
   end

   task automatic pruefe(input string name, input logic [31:0] ist, input logic [31:0] soll);
      total++;
      if (ist !== soll) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, ist, soll);
      end
   endtask

   // one CPU access, called at a negedge; returns on the negedge after the acknowledge
   task automatic zugriff(input logic [31:0] adr, input logic [31:0] wd, input logic rd, input logic wr,
                          input int lat, output logic [31:0] daten, output int zyklen, output int strobes,
                          output logic gotRd, output logic gotWr, output logic pulsOk);
      ramLatenz = lat;
      DatenAdresse = adr;
      DatenVonCPU = wd;
      LeseDaten = rd;
      SchreibeDaten = wr;
      zyklen = 0;
      strobes = 0;
      while (!(DatenGeladen || DatenGespeichert) && zyklen < 100) begin
         @(negedge Clock);
         zyklen++;
         if (RAMLesenAn || RAMSchreibenAn) strobes++;
      end
      gotRd = DatenGeladen;
      gotWr = DatenGespeichert;
      daten = DatenZuCPU;
      LeseDaten = 1'b0;
      SchreibeDaten = 1'b0;
      @(negedge Clock);
      pulsOk = !DatenGeladen && !DatenGespeichert;
   endtask

   typedef struct {
      logic [31:0] adr;
      logic [31:0] wd;
      logic        rd;
      logic        wr;
      int          lat;
      logic [31:0] expDaten;
      logic [7:0]  expLed;
      int          expZyklen;
      int          expStrobes;
   } vektor_t;

   vektor_t tabelle [13];

   initial begin
      logic [31:0] d, v1, v2;
      int z, s, s1, s2, acks;
      logic gr, gw, po;

      tabelle[0]  = '{32'h0000_0005, 32'h1234_5678, 1'b0, 1'b1, 2, 32'h0, 8'h00, 3, 2};
      tabelle[1]  = '{32'h0000_0005, 32'h0,         1'b1, 1'b0, 3, 32'h1234_5678, 8'h00, 4, 3};
      tabelle[2]  = '{32'h0000_01FF, 32'hCAFE_F00D, 1'b0, 1'b1, 1, 32'h0, 8'h00, 2, 1};
      tabelle[3]  = '{32'h0000_00FF, 32'h0,         1'b1, 1'b0, 1, 32'hCAFE_F00D, 8'h00, 2, 1};
      tabelle[4]  = '{32'h8000_0000, 32'h0000_00A5, 1'b0, 1'b1, 1, 32'h0, 8'hA5, 1, 0};
      tabelle[5]  = '{32'h8000_0000, 32'h0,         1'b1, 1'b0, 1, 32'h0000_00A5, 8'hA5, 1, 0};
      tabelle[6]  = '{32'h8000_0004, 32'h0,         1'b1, 1'b0, 1, 32'h0000_000A, 8'hA5, 1, 0};
      tabelle[7]  = '{32'h8000_0004, 32'h0000_00FF, 1'b0, 1'b1, 1, 32'h0, 8'hA5, 1, 0};
      tabelle[8]  = '{32'h8000_0000, 32'h0000_003C, 1'b1, 1'b1, 1, 32'h0, 8'h3C, 1, 0};
      tabelle[9]  = '{32'h8000_000C, 32'h0,         1'b1, 1'b0, 1, 32'h0, 8'h3C, 1, 0};
      tabelle[10] = '{32'h8000_0000, 32'hFFFF_FF17, 1'b0, 1'b1, 1, 32'h0, 8'h17, 1, 0};
      tabelle[11] = '{32'h0000_0010, 32'h0000_0055, 1'b1, 1'b1, 2, 32'h0, 8'h17, 3, 2};
      tabelle[12] = '{32'h0000_0010, 32'h0,         1'b1, 1'b0, 2, 32'h0000_0055, 8'h17, 3, 2};

      Reset = 1'b0;
      DatenAdresse = '0;
      DatenVonCPU = '0;
      LeseDaten = 1'b0;
      SchreibeDaten = 1'b0;
      Taster = 4'b1010;
      repeat (3) @(negedge Clock);
      pruefe("reset_acks", 32'({DatenGeladen, DatenGespeichert}), 32'h0);
      pruefe("reset_strobes", 32'({RAMLesenAn, RAMSchreibenAn}), 32'h0);
      pruefe("reset_led", 32'(Led), 32'h0);
      pruefe("reset_datenzucpu", DatenZuCPU, 32'h0);
      pruefe("reset_busfehler", 32'(BusFehler), 32'h0);
      Reset = 1'b1;
      repeat (4) @(negedge Clock);

      for (int i = 0; i < 13; i++) begin
         zugriff(tabelle[i].adr, tabelle[i].wd, tabelle[i].rd, tabelle[i].wr, tabelle[i].lat, d, z, s, gr, gw, po);
         pruefe($sformatf("v%0d_latency", i), 32'(z), 32'(tabelle[i].expZyklen));
         pruefe($sformatf("v%0d_strobes", i), 32'(s), 32'(tabelle[i].expStrobes));
         pruefe($sformatf("v%0d_write_ack", i), 32'(gw), 32'(tabelle[i].wr));
         pruefe($sformatf("v%0d_read_ack", i), 32'(gr), 32'(tabelle[i].rd && !tabelle[i].wr));
         pruefe($sformatf("v%0d_single_pulse", i), 32'(po), 32'h1);
         pruefe($sformatf("v%0d_led", i), 32'(Led), 32'(tabelle[i].expLed));
         if (tabelle[i].rd && !tabelle[i].wr) begin
            pruefe($sformatf("v%0d_data", i), d, tabelle[i].expDaten);
            pruefe($sformatf("v%0d_data_hold", i), DatenZuCPU, tabelle[i].expDaten);
         end
      end

      // cycle counter: value equals edges since reset release; two reads keep that distance
      s1 = tbZyklen;
      zugriff(32'h8000_0008, 32'h0, 1'b1, 1'b0, 1, v1, z, s, gr, gw, po);
      pruefe("counter_first", v1, 32'(s1));
      repeat (10) @(negedge Clock);
      s2 = tbZyklen;
      zugriff(32'h8000_0008, 32'h0, 1'b1, 1'b0, 1, v2, z, s, gr, gw, po);
      pruefe("counter_second", v2, 32'(s2));
      pruefe("counter_diff", v2 - v1, 32'(s2 - s1));

      // request held through the acknowledge is accepted again
      DatenAdresse = 32'h8000_0000;
      DatenVonCPU = 32'h0000_0011;
      SchreibeDaten = 1'b1;
      acks = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge Clock);
         if (DatenGespeichert) acks++;
      end
      SchreibeDaten = 1'b0;
      pruefe("held_request_acks", 32'(acks), 32'd2);
      pruefe("held_request_led", 32'(Led), 32'h11);

`ifdef DATEN_BUS_TIMEOUT_EN
      zugriff(32'h0000_0040, 32'h0, 1'b1, 1'b0, 0, d, z, s, gr, gw, po);
      pruefe("timeout_latency", 32'(z), 32'd17);
      pruefe("timeout_strobes", 32'(s), 32'd16);
      pruefe("timeout_data", d, 32'hDEAD_BEEF);
      pruefe("timeout_busfehler", 32'(BusFehler), 32'h1);
      zugriff(32'h8000_000C, 32'h0, 1'b1, 1'b0, 1, d, z, s, gr, gw, po);
      pruefe("status_error_bit", d, 32'h1);
      zugriff(32'h8000_000C, 32'h1, 1'b0, 1'b1, 1, d, z, s, gr, gw, po);
      pruefe("busfehler_cleared", 32'(BusFehler), 32'h0);
`endif

      // reset while waiting on a silent RAM, with a late completion during reset
      ramLatenz = 0;
      DatenAdresse = 32'h0000_0020;
      LeseDaten = 1'b1;
      repeat (3) @(negedge Clock);
      pruefe("midreset_strobe_before", 32'(RAMLesenAn), 32'h1);
      Reset = 1'b0;
      RAMDatenRaus = 32'h7777_7777;
      RAMDatenBereit = 1'b1;
      @(negedge Clock);
      pruefe("midreset_strobes", 32'({RAMLesenAn, RAMSchreibenAn}), 32'h0);
      pruefe("midreset_acks", 32'({DatenGeladen, DatenGespeichert}), 32'h0);
      pruefe("midreset_led", 32'(Led), 32'h0);
      pruefe("midreset_datenzucpu", DatenZuCPU, 32'h0);
      LeseDaten = 1'b0;
      @(negedge Clock);
      pruefe("midreset_no_late_ack", 32'({DatenGeladen, DatenGespeichert}), 32'h0);
      Reset = 1'b1;
      @(negedge Clock);
      zugriff(32'h8000_0000, 32'h0, 1'b1, 1'b0, 1, d, z, s, gr, gw, po);
      pruefe("after_reset_idle_latency", 32'(z), 32'd1);
      pruefe("after_reset_led_read", d, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
